// File: rtl/rf_frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_frame_pkg : frame states, field/preamble constants, per-phase bit helpers
// Rev 1.0      | lead-in phase selected by RF_TX_LEADIN_EN
// ---------------------------------------------------------------------------
package rf_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    PRE  = 3'd2,
    FA   = 3'd3,
    SYNC = 3'd4,
    FB   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int         PREAMBLE_LEN = 8;
  localparam int         SYNC_LEN     = 8;
  localparam int         FIELD_A_W    = 27;
  localparam int         FIELD_B_W    = 32;
  localparam logic [1:0] LEADIN_BITS  = 2'b10;
  localparam int         BITCNT_W     = 6;

  function automatic state_t next_phase(input state_t s);
    case (s)
`ifdef RF_TX_LEADIN_EN
      IDLE:    return LEAD;
`else
      IDLE:    return PRE;
`endif
      LEAD:    return PRE;
      PRE:     return FA;
      FA:      return SYNC;
      SYNC:    return FB;
      FB:      return DONE;
      default: return IDLE;
    endcase
  endfunction

  // Bits are sent from the highest index down, so a phase starts at its last index.
  function automatic logic [BITCNT_W-1:0] phase_last_idx(input state_t s);
    case (s)
      LEAD:    return BITCNT_W'($bits(LEADIN_BITS) - 1);
      PRE:     return BITCNT_W'(PREAMBLE_LEN - 1);
      FA:      return BITCNT_W'(FIELD_A_W - 1);
      SYNC:    return BITCNT_W'(SYNC_LEN - 1);
      FB:      return BITCNT_W'(FIELD_B_W - 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic phase_bit(input state_t s,
                                     input logic [BITCNT_W-1:0]  idx,
                                     input logic [FIELD_A_W-1:0] fa,
                                     input logic [FIELD_B_W-1:0] fb);
    logic [FIELD_A_W-1:0] sa;
    logic [FIELD_B_W-1:0] sb;
    logic [1:0]           sl;
    sa = fa >> idx;
    sb = fb >> idx;
    sl = LEADIN_BITS >> idx;
    case (s)
      LEAD:      return sl[0];
      PRE, SYNC: return 1'b1;
      FA:        return sa[0];
      FB:        return sb[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_slot_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_slot_timer : bit-slot clock counter, slot_end strobe and next-clock pulse window
// Rev 1.0
// ---------------------------------------------------------------------------
module rf_slot_timer #(
  parameter int BIT_CLKS  = 10000,
  parameter int PULSE_POS = 100,
  parameter int PULSE_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_slot_end,
  output logic o_win_next
);

  localparam int               CNT_W  = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int               CNT_WX = CNT_W + 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  // One extra bit so the window end may equal BIT_CLKS itself.
  localparam logic [CNT_W:0]   c_win_lo = CNT_WX'(PULSE_POS);
  localparam logic [CNT_W:0]   c_win_hi = CNT_WX'(PULSE_POS + PULSE_W);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W:0]   w_cnt_next_x;

  always_comb begin
    w_cnt_next = '0;
    if (i_run && (r_cnt != c_last)) begin
      w_cnt_next = r_cnt + c_one;
    end
  end

  assign o_slot_end   = i_run && (r_cnt == c_last);
  assign w_cnt_next_x = {1'b0, w_cnt_next};
  assign o_win_next   = (w_cnt_next_x >= c_win_lo) && (w_cnt_next_x < c_win_hi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_frame_tx : OOK frame transmitter (preamble, field_a, sync, field_b)
// Rev 1.0     | RF_TX_LEADIN_EN adds a two-slot lead-in before the preamble
// ---------------------------------------------------------------------------
module rf_frame_tx
  import rf_frame_pkg::*;
#(
  parameter int BIT_CLKS  = 10000,
  parameter int PULSE_POS = 100,
  parameter int PULSE_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_mode,
  input  logic                 start,
  input  logic [FIELD_A_W-1:0] field_a,
  input  logic [FIELD_B_W-1:0] field_b,
  output logic                 rfout,
  output logic                 busy,
  output logic                 done
);

  localparam logic [BITCNT_W-1:0] c_bit_one = BITCNT_W'(1);

  generate
    if ((PULSE_POS + PULSE_W > BIT_CLKS) || (PULSE_W < 1) || (PULSE_POS < 0)) begin : g_bad_pulse
      $error("rf_frame_tx: pulse window does not fit inside one bit slot");
    end
  endgenerate

  state_t               r_state;
  logic [BITCNT_W-1:0]  r_bitcnt;
  logic [FIELD_A_W-1:0] r_fa;
  logic [FIELD_B_W-1:0] r_fb;
  logic                 w_accept;
  logic                 w_run;
  logic                 w_slot_end;
  logic                 w_win_next;
  logic                 w_bit_next;
  state_t               w_next_phase;

  assign w_accept     = (r_state == IDLE) && start && !rx_mode;
  assign w_run        = !(r_state inside {IDLE, DONE});
  assign w_next_phase = next_phase(r_state);

  rf_slot_timer #(
    .BIT_CLKS  (BIT_CLKS),
    .PULSE_POS (PULSE_POS),
    .PULSE_W   (PULSE_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .o_slot_end (w_slot_end),
    .o_win_next (w_win_next)
  );

  // Bit that will be on air during the next clock, so rfout can be a flop
  // that is still aligned with the slot clock index.
  always_comb begin
    w_bit_next = 1'b0;
    if (w_accept) begin
      w_bit_next = phase_bit(w_next_phase, phase_last_idx(w_next_phase), field_a, field_b);
    end else if (w_run) begin
      if (!w_slot_end) begin
        w_bit_next = phase_bit(r_state, r_bitcnt, r_fa, r_fb);
      end else if (r_bitcnt != '0) begin
        w_bit_next = phase_bit(r_state, r_bitcnt - c_bit_one, r_fa, r_fb);
      end else begin
        w_bit_next = phase_bit(w_next_phase, phase_last_idx(w_next_phase), r_fa, r_fb);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_fa     <= '0;
      r_fb     <= '0;
      rfout    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rfout <= w_bit_next && w_win_next;
      done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= w_next_phase;
            r_bitcnt <= phase_last_idx(w_next_phase);
            r_fa     <= field_a;
            r_fb     <= field_b;
            busy     <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          if (w_slot_end) begin
            if (r_bitcnt != '0) begin
              r_bitcnt <= r_bitcnt - c_bit_one;
            end else begin
              r_state  <= w_next_phase;
              r_bitcnt <= phase_last_idx(w_next_phase);
              if (w_next_phase == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rf_frame_tx : scoreboard bench for rf_frame_tx, one short-slot and one end-of-slot-pulse instance
// Rev 1.0        | expected frame follows RF_TX_LEADIN_EN when it is defined
// ---------------------------------------------------------------------------
module tb_rf_frame_tx;

  localparam int BC_A = 20;
  localparam int PP_A = 2;
  localparam int PW_A = 1;
  localparam int BC_B = 200;
  localparam int PP_B = 197;
  localparam int PW_B = 3;
`ifdef RF_TX_LEADIN_EN
  localparam int NSLOTS = 77;
  localparam int ZERO_PULSES = 17;
`else
  localparam int NSLOTS = 75;
  localparam int ZERO_PULSES = 16;
`endif

  logic        clk;
  logic        rst;
  logic        rx_mode;
  logic        start_a, start_b;
  logic [26:0] fa_a, fa_b;
  logic [31:0] fb_a, fb_b;
  logic        rfout_a, busy_a, done_a;
  logic        rfout_b, busy_b, done_b;

  rf_frame_tx #(.BIT_CLKS(BC_A), .PULSE_POS(PP_A), .PULSE_W(PW_A)) dut_a (
    .clk(clk), .rst(rst), .rx_mode(rx_mode), .start(start_a),
    .field_a(fa_a), .field_b(fb_a), .rfout(rfout_a), .busy(busy_a), .done(done_a)
  );

  rf_frame_tx #(.BIT_CLKS(BC_B), .PULSE_POS(PP_B), .PULSE_W(PW_B)) dut_b (
    .clk(clk), .rst(rst), .rx_mode(rx_mode), .start(start_b),
    .field_a(fa_b), .field_b(fb_b), .rfout(rfout_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  int exp_a_q[$], exp_b_q[$];
  int done_a_q[$], done_b_q[$];

  task automatic push_frame(input bit sel, input logic [26:0] fa, input logic [31:0] fb);
    int bits[$];
    bits = {};
`ifdef RF_TX_LEADIN_EN
    bits.push_back(1);
    bits.push_back(0);
`endif
    for (int i = 0; i < 8; i++) bits.push_back(1);
    for (int i = 26; i >= 0; i--) bits.push_back(int'(fa[i]));
    for (int i = 0; i < 8; i++) bits.push_back(1);
    for (int i = 31; i >= 0; i--) bits.push_back(int'(fb[i]));
    foreach (bits[j]) begin
      if (sel) exp_b_q.push_back(bits[j]);
      else     exp_a_q.push_back(bits[j]);
    end
  endtask

  // 0 = silent slot, 1 = one well-formed pulse, 2 = malformed.
  function automatic int slot_code(input int nh, input int fh, input int lh, input int pos, input int w);
    if (nh == 0) return 0;
    if (nh == w && fh == pos && lh == pos + w - 1) return 1;
    return 2;
  endfunction

  int a_k = 0, a_nh = 0, a_fh = 0, a_lh = 0, a_sc = 0, a_stray = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      a_k = 0;
    end else begin
      if (rfout_a && !busy_a) a_stray++;
      if (busy_a) begin
        a_sc = a_k % BC_A;
        if (a_sc == 0) begin a_nh = 0; a_fh = 0; a_lh = 0; end
        if (rfout_a) begin
          if (a_nh == 0) a_fh = a_sc;
          a_lh = a_sc;
          a_nh++;
        end
        if (a_sc == BC_A - 1) begin
          check_val("A_slot_expected", exp_a_q.size() != 0, 1);
          if (exp_a_q.size() != 0)
            check_val($sformatf("A_slot%0d", a_k / BC_A),
                      slot_code(a_nh, a_fh, a_lh, PP_A, PW_A), exp_a_q.pop_front());
        end
        a_k++;
      end else if (a_k != 0) begin
        check_val("A_frame_align", a_k % BC_A, 0);
        check_val("A_slots_left", exp_a_q.size(), 0);
        exp_a_q.delete();
        a_k = 0;
      end
      if (done_a) begin
        check_val("A_done_expected", done_a_q.size() != 0, 1);
        if (done_a_q.size() != 0) check_val("A_done_cycle", cyc, done_a_q.pop_front());
        check_val("A_busy_at_done", busy_a, 0);
      end
    end
  end

  int b_k = 0, b_nh = 0, b_fh = 0, b_lh = 0, b_sc = 0, b_stray = 0;
  int b_pulses = 0, b_busy = 0;
  logic b_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      b_k = 0;
      b_prev = 1'b0;
    end else begin
      if (rfout_b && !busy_b) b_stray++;
      if (rfout_b && !b_prev) b_pulses++;
      b_prev = rfout_b;
      if (busy_b) begin
        b_busy++;
        b_sc = b_k % BC_B;
        if (b_sc == 0) begin b_nh = 0; b_fh = 0; b_lh = 0; end
        if (rfout_b) begin
          if (b_nh == 0) b_fh = b_sc;
          b_lh = b_sc;
          b_nh++;
        end
        if (b_sc == BC_B - 1) begin
          check_val("B_slot_expected", exp_b_q.size() != 0, 1);
          if (exp_b_q.size() != 0)
            check_val($sformatf("B_slot%0d", b_k / BC_B),
                      slot_code(b_nh, b_fh, b_lh, PP_B, PW_B), exp_b_q.pop_front());
        end
        b_k++;
      end else if (b_k != 0) begin
        check_val("B_frame_align", b_k % BC_B, 0);
        check_val("B_slots_left", exp_b_q.size(), 0);
        exp_b_q.delete();
        b_k = 0;
      end
      if (done_b) begin
        check_val("B_done_expected", done_b_q.size() != 0, 1);
        if (done_b_q.size() != 0) check_val("B_done_cycle", cyc, done_b_q.pop_front());
        check_val("B_busy_at_done", busy_b, 0);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the start cycle.
  task automatic send(input bit sel, input logic [26:0] fa, input logic [31:0] fb, input bit accept);
    if (sel) begin fa_b = fa; fb_b = fb; start_b = 1'b1; end
    else     begin fa_a = fa; fb_a = fb; start_a = 1'b1; end
    if (accept) begin
      push_frame(sel, fa, fb);
      if (sel) done_b_q.push_back(cyc + NSLOTS * BC_B + 1);
      else     done_a_q.push_back(cyc + NSLOTS * BC_A + 1);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit);
    int n = 0;
    while (!(sel ? done_b : done_a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sel) check_val("B_done_seen", done_b, 1);
    else     check_val("A_done_seen", done_a, 1);
    @(negedge clk);
  endtask

  logic [26:0] rnd_a;
  logic [31:0] rnd_b;

  initial begin
    rst = 1'b0; rx_mode = 1'b0; start_a = 1'b0; start_b = 1'b0;
    fa_a = '0; fb_a = '0; fa_b = '0; fb_b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_rfout", rfout_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_busy_b", busy_b, 0);
    rst = 1'b1;
    @(negedge clk);

    // Long-slot instance with all-zero payload runs in the background.
    send(1, 27'h0, 32'h0, 1);

    send(0, 27'h5276276, 32'hDD595B5C, 1);
    wait_done(0, NSLOTS * BC_A + 20);

    rx_mode = 1'b1;
    send(0, 27'h7FFFFFF, 32'hFFFFFFFF, 0);
    repeat (30) @(negedge clk);
    check_val("rx_busy", busy_a, 0);
    rx_mode = 1'b0;
    @(negedge clk);

    send(0, 27'h1ABCDEF, 32'h12345678, 1);
    repeat (100) @(negedge clk);
    send(0, 27'h0000001, 32'h80000000, 0);
    wait_done(0, NSLOTS * BC_A + 20);

    send(0, 27'h2C3A5F1, 32'hA5F00F5A, 1);
    fa_a = ~27'h2C3A5F1;
    fb_a = ~32'hA5F00F5A;
    repeat (200) @(negedge clk);
    rx_mode = 1'b1;
    wait_done(0, NSLOTS * BC_A + 20);
    rx_mode = 1'b0;

    wait_done(1, NSLOTS * BC_B + 20);
    check_val("B_pulse_count", b_pulses, ZERO_PULSES);
    check_val("B_busy_cycles", b_busy, NSLOTS * BC_B);

    // Abort at slot 20, clock 5 of a frame.
    send(0, 27'h5555555, 32'hAAAAAAAA, 1);
    repeat (20 * BC_A + 5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("abort_rfout", rfout_a, 0);
    check_val("abort_busy", busy_a, 0);
    check_val("abort_done", done_a, 0);
    exp_a_q.delete();
    done_a_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("idle_after_abort", busy_a, 0);

    rnd_a = 27'($urandom);
    rnd_b = $urandom;
    send(0, rnd_a, rnd_b, 1);
    wait_done(0, NSLOTS * BC_A + 20);

    repeat (5) @(negedge clk);
    check_val("A_scoreboard_empty", exp_a_q.size() + done_a_q.size(), 0);
    check_val("B_scoreboard_empty", exp_b_q.size() + done_b_q.size(), 0);
    check_val("A_stray_pulses", a_stray, 0);
    check_val("B_stray_pulses", b_stray, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_frame_tx.md
RF_FRAME_TX -- requirements
Module: rf_frame_tx

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 10000, meaning clocks per bit slot (1 ms at 10 MHz).
REQ-002 SHALL have parameter PULSE_POS, default 100, meaning slot clock index at which a '1' pulse starts.
REQ-003 SHALL have parameter PULSE_W, default 1, meaning pulse width in clocks.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_mode  in  1  radio in receive mode; start ignored while high.
REQ-007 SHALL have port start  in  1  single-cycle frame request.
REQ-008 SHALL have port field_a  in  27  first payload field, MSB first.
REQ-009 SHALL have port field_b  in  32  second payload field, MSB first.
REQ-010 SHALL have port rfout  out  1  OOK pulse output to RF driver.
REQ-011 SHALL have port busy  out  1  frame in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse after last slot ends.

Function
REQ-013 SHALL send the frame in order: 8 preamble '1', field_a[26:0], 8 sync '1', field_b[31:0]; 75 slots without lead-in.
REQ-014 SHALL encode each bit as one BIT_CLKS slot: '1' drives rfout high for slot clocks PULSE_POS..PULSE_POS+PULSE_W-1; '0' keeps rfout low all slot.
REQ-015 SHALL use states IDLE, LEAD, PRE, FA, SYNC, FB, DONE; IDLE->(LEAD|PRE) on accepted start; each later state advances on its final slot's last clock; DONE->IDLE after one cycle.
REQ-016 SHALL accept start only in IDLE with rx_mode=0; otherwise start is dropped, not queued.
REQ-017 SHALL latch field_a and field_b on the accepting clock; later input changes do not affect the frame.
REQ-018 SHALL begin slot 0, clock 0, on the cycle after acceptance; busy rises that same cycle.
REQ-019 SHALL hold a slot counter ceil(log2(BIT_CLKS)) wide, wrapping BIT_CLKS-1 -> 0, and a 6-bit bit counter reloaded per state.
REQ-020 SHALL register rfout (no combinational path from counters to pin).
REQ-021 SHALL keep busy high through last slot's final clock, assert done one cycle in DONE with busy low.
REQ-022 SHALL ignore rx_mode rising mid-frame; frame completes.
REQ-023 SHALL treat PULSE_POS+PULSE_W > BIT_CLKS as illegal (elaboration assertion).

Reset
REQ-024 SHALL on rst low immediately force state IDLE, counters 0, rfout 0, busy 0, done 0, latched fields 0.
REQ-025 SHALL abort a frame on mid-frame reset with no further pulses; first start after release transmits full frame.

Configuration
REQ-026 SHALL, with RF_TX_LEADIN_EN defined, send 2 lead-in slots with constant bits '1','0' (LEAD state) before preamble, giving 77 slots.
REQ-027 SHALL, without RF_TX_LEADIN_EN, omit LEAD state and go IDLE->PRE directly.

Structure
REQ-028 SHALL put the state enumeration, PREAMBLE_LEN=8, SYNC_LEN=8, FIELD_A_W=27, FIELD_B_W=32, LEADIN_BITS=2'b10 in shared package rf_frame_pkg.
REQ-029 SHALL implement slot timing in one sub-module rf_slot_timer (slot counter, pulse window, slot_end strobe).

Verification (BIT_CLKS=20, PULSE_POS=2, PULSE_W=1 unless noted)
REQ-030 SHALL cover: start, field_a=27'h5276276, field_b=32'hDD595B5C, no macro -> 75 slots, pulses in slots 0-7, field_a ones, slots 35-42, field_b ones; done at cycle 1501 after start.
REQ-031 SHALL cover: same with RF_TX_LEADIN_EN -> pulse in slot 0, none in slot 1, preamble from slot 2, done at cycle 1541.
REQ-032 SHALL cover: start with rx_mode=1 -> busy stays 0, rfout never high; start while busy -> ignored, frame length unchanged.
REQ-033 SHALL cover: rst low at slot 20 clock 5 -> rfout, busy, done 0 same time step; next start sends complete frame.
REQ-034 SHALL cover: field_a/field_b changed one cycle after start -> transmitted bits equal originally latched values.
REQ-035 SHALL cover: default params, field_a=0, field_b=0 -> exactly 16 pulses each 1 clock wide at slot clock 100, busy 750000 cycles.
